// File: rtl/uart_rx_seq.sv
// Oversampling UART receive sequencer: synchronizes rxd, qualifies the start bit
// and times data/parity/stop bits. Define UART_RX_PARITY_EN to include the parity bit.
module uart_rx_seq #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int ODD_PARITY   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic rxd,
    output logic shift,
    output logic rx_bit,
    output logic load,
    output logic checkstop,
    output logic busy,
    output logic parity_err,
    output logic framing_err
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, HOLD} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [BW-1:0] bitidx, bitidx_d;
    logic          sync1, rx_s;
    logic          bit_end;
    logic          shift_d, rx_bit_d, load_d, parity_err_d, framing_err_d;
`ifdef UART_RX_PARITY_EN
    logic          par_acc, par_acc_d;
    logic          perr_n, perr_n_d;
`endif

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bitidx      <= '0;
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            shift       <= 1'b0;
            rx_bit      <= 1'b0;
            load        <= 1'b0;
            checkstop   <= 1'b0;
            busy        <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_acc     <= 1'b0;
            perr_n      <= 1'b0;
`endif
        end else begin
            sync1       <= rxd;
            rx_s        <= sync1;
            state       <= state_d;
            cnt         <= cnt_d;
            bitidx      <= bitidx_d;
            shift       <= shift_d;
            rx_bit      <= rx_bit_d;
            load        <= load_d;
            checkstop   <= load_d;
            busy        <= (state_d != IDLE);
            parity_err  <= parity_err_d;
            framing_err <= framing_err_d;
`ifdef UART_RX_PARITY_EN
            par_acc     <= par_acc_d;
            perr_n      <= perr_n_d;
`endif
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt + 1'b1;
        bitidx_d = bitidx;
`ifdef UART_RX_PARITY_EN
        par_acc_d = par_acc;
        perr_n_d  = perr_n;
`endif
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (en && !rx_s) state_d = START;
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d  = DATA;
                        bitidx_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_acc_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_acc_d = par_acc ^ rx_s;
`endif
                    if (bitidx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitidx_d = bitidx + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    perr_n_d = par_acc ^ rx_s ^ 1'(ODD_PARITY);
                    state_d  = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : HOLD;
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // Disable overrides every transition, including a pending stop-bit load.
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        shift_d       = 1'b0;
        load_d        = 1'b0;
        rx_bit_d      = rx_bit;
        parity_err_d  = parity_err;
        framing_err_d = framing_err;
        if (en && bit_end) begin
            if (state == DATA) begin
                shift_d  = 1'b1;
                rx_bit_d = rx_s;
            end else if (state == STOP) begin
                load_d        = 1'b1;
                framing_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
                parity_err_d  = perr_n;
`else
                parity_err_d  = 1'b0;
`endif
            end
        end
    end

endmodule
